// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch (IF) stage of the 5-stage pipeline.
//   Owns the PC and drives instruction-memory ReadAddress (combinational).
//   The memory returns Instruction one cycle later, and this stage registers
//   it into the IF/ID pipeline register.
//   Handles sequential increment with wrap, decode stall (replay of the
//   pending address), and branch redirect with wrong-path squash.
//
// Optional feature: define FETCH_HALT_DETECT_EN to stop fetching after an
//   instruction whose top nibble is 4'hF. Only a redirect or a reset resumes
//   fetching. Without the macro, opcode 4'hF is an ordinary instruction and
//   halted is tied to 0.
//
// Ports:
//   clk             in   pipeline clock, rising edge
//   rst             in   asynchronous active-low reset
//   stall           in   decode stall: hold PC and IF/ID
//   redirect        in   taken branch/jump: squash the wrong path
//   redirect_target in   new PC when redirect=1
//   Instruction     in   registered memory data for the previous ReadAddress
//   ReadAddress     out  instruction-memory address (combinational)
//   id_instr        out  IF/ID instruction
//   id_pc           out  address of id_instr
//   id_valid        out  IF/ID holds a real instruction
//   addr_err        out  sticky flag: out-of-range redirect target seen
//   halted          out  fetch halted (halt-detect builds only)
module fetch_unit #(
    parameter int unsigned ADDR_LIMIT = 16,
    parameter int unsigned AW         = 16,
    parameter int unsigned IW         = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_target,
    input  logic [IW-1:0] Instruction,
    output logic [AW-1:0] ReadAddress,
    output logic [IW-1:0] id_instr,
    output logic [AW-1:0] id_pc,
    output logic          id_valid,
    output logic          addr_err,
    output logic          halted
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] f_pc_q, f_pc_d;     // address whose data is on Instruction
    logic          f_valid_q, f_valid_d;
    logic [IW-1:0] id_instr_q, id_instr_d;
    logic [AW-1:0] id_pc_q, id_pc_d;
    logic          id_valid_q, id_valid_d;
    logic          addr_err_q, addr_err_d;
    state_e        state_q, state_d;

    logic          tgt_ok_c;
    logic [AW-1:0] tgt_c;

    // Wrapping PC increment.
    function automatic logic [AW-1:0] inc(input logic [AW-1:0] x);
        return (x == AW'(ADDR_LIMIT - 1)) ? '0 : x + AW'(1);
    endfunction

    // Out-of-range redirect targets are forced to address 0.
    always_comb begin
        tgt_ok_c = ({1'b0, redirect_target} < (AW + 1)'(ADDR_LIMIT));
        tgt_c    = tgt_ok_c ? redirect_target : '0;
    end

    // Memory address: stall/halt replay f_pc so Instruction keeps its word.
    always_comb begin
        ReadAddress = pc_q;
        if (!rst) begin
            ReadAddress = '0;
        end else if (redirect) begin
            ReadAddress = tgt_c;
        end else if (stall || (state_q == ST_HALTED)) begin
            ReadAddress = f_pc_q;
        end
    end

    // Next-state logic: redirect > halted > stall > normal fetch.
    always_comb begin
        pc_d       = pc_q;
        f_pc_d     = f_pc_q;
        f_valid_d  = f_valid_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        id_valid_d = id_valid_q;
        addr_err_d = addr_err_q;
        state_d    = state_q;

        if (redirect) begin
            f_pc_d     = tgt_c;
            f_valid_d  = 1'b1;
            pc_d       = inc(tgt_c);
            id_valid_d = 1'b0;
            state_d    = ST_RUN;
            if (!tgt_ok_c) begin
                addr_err_d = 1'b1;
            end
        end else if (state_q == ST_HALTED) begin
            id_valid_d = 1'b0;
        end else if (!stall) begin
            id_instr_d = Instruction;
            id_pc_d    = f_pc_q;
            id_valid_d = f_valid_q;
            f_pc_d     = pc_q;
            f_valid_d  = 1'b1;
            pc_d       = inc(pc_q);
`ifdef FETCH_HALT_DETECT_EN
            // Halt word goes to decode; nothing behind it is fetched.
            if (f_valid_q && (Instruction[IW-1 -: 4] == 4'hF)) begin
                f_valid_d = 1'b0;
                pc_d      = pc_q;
                state_d   = ST_HALTED;
            end
`endif
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= '0;
            f_pc_q     <= '0;
            f_valid_q  <= 1'b0;
            id_instr_q <= '0;
            id_pc_q    <= '0;
            id_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
            state_q    <= ST_RUN;
        end else begin
            pc_q       <= pc_d;
            f_pc_q     <= f_pc_d;
            f_valid_q  <= f_valid_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            id_valid_q <= id_valid_d;
            addr_err_q <= addr_err_d;
            state_q    <= state_d;
        end
    end

    assign id_instr = id_instr_q;
    assign id_pc    = id_pc_q;
    assign id_valid = id_valid_q;
    assign addr_err = addr_err_q;
`ifdef FETCH_HALT_DETECT_EN
    assign halted   = (state_q == ST_HALTED);
`else
    assign halted   = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch (IF) stage of the 5-stage pipeline. Sits directly upstream of the instruction memory and drives its ReadAddress.
- Consumes the memory's registered Instruction, which has 1-cycle synchronous read latency.
- Produces the IF/ID pipeline register for decode.
- Owns the PC, sequential increment, PC wrap, decode-stall hold and branch redirect with wrong-path squash.

Parameters:
- ADDR_LIMIT, 16: number of instruction-memory words. PC range is 0..ADDR_LIMIT-1.
- AW, 16: PC / address width.
- IW, 16: instruction width.

Ports:
- clk  in  1  pipeline clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  decode-stage stall; hold PC and IF/ID.
- redirect  in  1  branch/jump taken; squash wrong path.
- redirect_target  in  AW  new PC when redirect=1.
- Instruction  in  IW  registered memory output; holds word at the address presented on the previous edge.
- ReadAddress  out  AW  address to instruction memory (combinational).
- id_instr  out  IW  IF/ID instruction.
- id_pc  out  AW  address of id_instr.
- id_valid  out  1  IF/ID holds a real instruction.
- addr_err  out  1  sticky: out-of-range redirect seen.
- halted  out  1  halt state (see Optional Feature).

Behaviour:
Registers and reset:
- Registers: pc, f_pc (address whose data is on Instruction this cycle), f_valid, id_instr, id_pc, id_valid, addr_err, state.
- rst=0, asynchronous: pc=0, f_pc=0, f_valid=0, id_instr=0, id_pc=0, id_valid=0, addr_err=0, halted=0, state=RUN.
- ReadAddress is 0 during reset.

ReadAddress (combinational), by priority:
- redirect=1: tgt.
- else stall=1 or state=HALTED: f_pc (replay, so memory re-reads the pending word).
- else: pc.
- tgt = redirect_target if < ADDR_LIMIT, else 0.

Per edge, in priority order:
- redirect:
  - f_pc<=tgt, f_valid<=1, pc<=inc(tgt), id_valid<=0 (id_instr/id_pc hold).
  - state<=RUN.
  - If redirect_target>=ADDR_LIMIT, addr_err<=1.
  - Redirect beats stall and halt.
- stall: pc, f_pc, f_valid, id_* all hold. Instruction stays equal to Mem[f_pc] through the replay.
- normal RUN:
  - id_instr<=Instruction, id_pc<=f_pc, id_valid<=f_valid.
  - f_pc<=pc, f_valid<=1, pc<=inc(pc).

Arithmetic and latency:
- inc(x) = (x==ADDR_LIMIT-1) ? 0 : x+1. PC wraps with no error.
- Fetch latency: the address issued at edge k appears in IF/ID at edge k+1.
- First valid IF/ID word: second edge after reset release, with id_pc=0.

Invariants:
- No instruction is skipped or duplicated across any stall length, including stall asserted on the first cycle after reset (f_valid=0 is held).
- A redirect on the same cycle as the first post-stall cycle behaves as a plain redirect.
- addr_err clears only on reset.

Optional Feature:
- Macro: FETCH_HALT_DETECT_EN.
- Defined:
  - In RUN, on a normal edge where f_valid=1 and Instruction[IW-1:IW-4]==4'hF, the halt word is captured into IF/ID normally; f_valid<=0, pc holds, state<=HALTED.
  - In HALTED: halted=1, ReadAddress=f_pc, id_valid<=0 every edge, pc frozen, stall ignored.
  - Exit only via redirect (resume RUN at tgt) or reset.
- Undefined: opcode 4'hF is an ordinary instruction; state is always RUN; halted tied 0.

Test Plan:
- Reset release, no stall/redirect, 6 cycles, behavioural memory Mem[i]=16'h1000+i:
  - ReadAddress 0,1,2,3,4,5.
  - id_valid=0 after edge 1; after edge 2 id_pc=0, id_instr=16'h1000; after edge 3 id_pc=1, id_instr=16'h1001.
- Stall high 3 cycles while f_pc=3, id_pc=2:
  - ReadAddress=3 and id_pc=2 held throughout.
  - Edge after release: id_pc=3, id_instr=16'h1003; next edge id_pc=4 (no skip, no duplicate).
- redirect=1, target=9 while pc=5:
  - ReadAddress=9 that cycle.
  - Next edge: id_valid=0.
  - Following edge: id_pc=9, id_instr=16'h1009, id_valid=1.
- PC wrap and out-of-range target:
  - Run to pc=15: next ReadAddress=0, addr_err=0.
  - Then redirect target=20: ReadAddress=0, addr_err=1 stays set until rst.
- redirect and stall same cycle, target=2: redirect wins; ReadAddress=2, id_valid=0 next edge.
- rst pulled low mid-run between edges: all outputs 0 immediately (asynchronous), ReadAddress=0.
- With FETCH_HALT_DETECT_EN, Mem[4]=16'hF000:
  - id_pc=4 captured, then halted=1, id_valid=0, ReadAddress frozen.
  - redirect target=0 resumes fetch at 0.
